// File: rtl/isa_pkg.sv
// ============================================================================
// Module  : isa_pkg
// Brief   : Opcodes, instruction field positions and fetch FSM encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package isa_pkg;

  localparam logic [4:0] OP_J    = 5'b00001;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam int OP_MSB  = 31;
  localparam int OP_LSB  = 27;
  localparam int T_MSB   = 26;
  localparam int T_LSB   = 0;
  localparam int N_MSB   = 16;
  localparam int N_LSB   = 0;

  localparam int RSTATUS = 30;
  localparam int RLINK   = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/next_pc_calc.sv
// ============================================================================
// Module  : next_pc_calc
// Brief   : Combinational next-PC resolution for the instruction in execute.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module next_pc_calc
  import isa_pkg::*;
#(
  parameter int PC_WIDTH = 12
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic [31:0]         instr,
  input  logic [31:0]         rs_data,
  input  logic                alu_ne,
  input  logic                alu_lt,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                is_jal
);

  logic [4:0]          w_op;
  logic [PC_WIDTH-1:0] w_seq;
  logic [PC_WIDTH-1:0] w_target;
  logic [PC_WIDTH-1:0] w_branch;
  logic [31:0]         w_n_sext;
  logic                w_unused;

  assign w_op     = instr[OP_MSB:OP_LSB];
  assign w_seq    = pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
  assign w_target = instr[T_LSB +: PC_WIDTH];
  assign w_n_sext = {{(31-N_MSB){instr[N_MSB]}}, instr[N_MSB:N_LSB]};
  // Only the low PC bits of the offset matter; the add wraps with the PC.
  assign w_branch = w_seq + w_n_sext[PC_WIDTH-1:0];
  assign w_unused = ^{instr[T_MSB:N_MSB+1], w_n_sext[31:PC_WIDTH]};

  assign is_jal = (w_op == OP_JAL);

  always_comb begin
    next_pc = w_seq;
    case (w_op)
      OP_J, OP_JAL: next_pc = w_target;
      OP_JR:        next_pc = rs_data[PC_WIDTH-1:0];
      OP_BNE:       if (alu_ne) next_pc = w_branch;
      OP_BLT:       if (alu_lt) next_pc = w_branch;
      OP_BEX:       if (rs_data != 32'd0) next_pc = w_target;
      default:      next_pc = w_seq;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module  : fetch_unit
// Brief   : Fetch / next-PC stage: REQ-EXEC sequencing, jal link, halt detect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import isa_pkg::*;
#(
  parameter int                  PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] HALT_PC  = {PC_WIDTH{1'b1}},
  parameter bit                  HALT_EN  = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] address_imem,
  input  logic [31:0]         q_imem,
  input  logic                stall,
  input  logic [31:0]         rs_data,
  input  logic                alu_ne,
  input  logic                alu_lt,
  output logic [31:0]         instr_out,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                instr_valid,
  output logic                link_we,
  output logic [31:0]         link_data,
  output logic                halted
);

  fetch_state_e        r_state;
  fetch_state_e        w_state_next;
  logic [PC_WIDTH-1:0] r_pc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] w_branch_pc;
  logic [31:0]         r_instr;
  logic                w_capture;
  logic                w_is_jal;

  next_pc_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc_calc (
    .pc      (r_pc),
    .instr   (r_instr),
    .rs_data (rs_data),
    .alu_ne  (alu_ne),
    .alu_lt  (alu_lt),
    .next_pc (w_branch_pc),
    .is_jal  (w_is_jal)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (w_capture) r_instr <= q_imem;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: w_state_next = REQ;
      REQ: begin
        if (HALT_EN && (r_pc == HALT_PC)) begin
          w_state_next = HALT;
        end else begin
          w_state_next = EXEC;
          w_capture    = 1'b1;
        end
      end
      EXEC: begin
        // A stalled instruction keeps its PC, so the imem address is not advanced.
        if (!stall) begin
          w_pc_next    = w_branch_pc;
          w_state_next = REQ;
        end
      end
      HALT:    w_state_next = HALT;
      default: w_state_next = IDLE;
    endcase
  end

  assign address_imem = r_pc;
  assign instr_out    = r_instr;
  assign pc_out       = r_pc;
  assign instr_valid  = (r_state == EXEC);
  assign halted       = (r_state == HALT);
  assign link_we      = instr_valid & w_is_jal;
  assign link_data    = link_we ? ({{(32-PC_WIDTH){1'b0}}, r_pc} + 32'd1) : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module  : tb_fetch_unit
// Brief   : Self-checking bench for fetch_unit: directed program runs plus
//           randomized episodes against a behavioural fetch model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  localparam int c_PERIOD = 20;
  localparam int c_HALT   = 17;

  localparam logic [4:0] c_OP_J    = 5'b00001;
  localparam logic [4:0] c_OP_BNE  = 5'b00010;
  localparam logic [4:0] c_OP_JAL  = 5'b00011;
  localparam logic [4:0] c_OP_JR   = 5'b00100;
  localparam logic [4:0] c_OP_ADDI = 5'b00101;
  localparam logic [4:0] c_OP_BLT  = 5'b00110;
  localparam logic [4:0] c_OP_SETX = 5'b10101;
  localparam logic [4:0] c_OP_BEX  = 5'b10110;

  localparam int c_M_IDLE = 0;
  localparam int c_M_REQ  = 1;
  localparam int c_M_EXEC = 2;
  localparam int c_M_HALT = 3;

  logic        clock   = 1'b0;
  logic        reset   = 1'b1;
  logic [11:0] address_imem;
  logic [31:0] q_imem;
  logic        stall   = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic        alu_ne  = 1'b0;
  logic        alu_lt  = 1'b0;
  logic [31:0] instr_out;
  logic [11:0] pc_out;
  logic        instr_valid;
  logic        link_we;
  logic [31:0] link_data;
  logic        halted;

  logic [31:0] mem [0:4095];

  int checks = 0;
  int errors = 0;

  int          m_mode  = c_M_IDLE;
  int          m_pc    = 0;
  logic [31:0] m_instr = 32'd0;

  fetch_unit #(
    .PC_WIDTH (12),
    .HALT_PC  (12'd17),
    .HALT_EN  (1'b1)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address_imem (address_imem),
    .q_imem       (q_imem),
    .stall        (stall),
    .rs_data      (rs_data),
    .alu_ne       (alu_ne),
    .alu_lt       (alu_lt),
    .instr_out    (instr_out),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .link_we      (link_we),
    .link_data    (link_data),
    .halted       (halted)
  );

  always #(c_PERIOD/2) clock = ~clock;

  assign q_imem = mem[address_imem];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [4:0] op, input int field);
    logic [26:0] f;
    f = 27'(field);
    return {op, f};
  endfunction

  // Next PC from the ISA rules, in plain integer arithmetic modulo 4096.
  function automatic int ref_next_pc(input int pc, input logic [31:0] ins,
                                     input logic [31:0] rs, input bit ne, input bit lt);
    int op, t, n, seq, br;
    op  = int'(ins[31:27]);
    t   = int'(ins[26:0]) % 4096;
    n   = int'(ins[16:0]);
    if (n >= 65536) n = n - 131072;
    seq = (pc + 1) % 4096;
    br  = (((pc + 1 + n) % 4096) + 4096) % 4096;
    case (op)
      1, 3:    return t;
      4:       return int'(rs % 32'd4096);
      2:       return ne ? br : seq;
      6:       return lt ? br : seq;
      22:      return (rs != 32'd0) ? t : seq;
      default: return seq;
    endcase
  endfunction

  // Behavioural fetch: wait one cycle, then alternate fetch / execute until halt PC.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_mode  <= c_M_IDLE;
      m_pc    <= 0;
      m_instr <= 32'd0;
    end else begin
      case (m_mode)
        c_M_IDLE: m_mode <= c_M_REQ;
        c_M_REQ: begin
          if (m_pc == c_HALT) m_mode <= c_M_HALT;
          else begin
            m_instr <= mem[m_pc];
            m_mode  <= c_M_EXEC;
          end
        end
        c_M_EXEC: begin
          if (!stall) begin
            m_pc   <= ref_next_pc(m_pc, m_instr, rs_data, alu_ne, alu_lt);
            m_mode <= c_M_REQ;
          end
        end
        default: m_mode <= m_mode;
      endcase
    end
  end

  always @(negedge clock) begin
    chk("valid", 32'(instr_valid), 32'(m_mode == c_M_EXEC));
    chk("halted", 32'(halted), 32'(m_mode == c_M_HALT));
    if (m_mode == c_M_REQ) chk("addr", 32'(address_imem), 32'(m_pc));
    if (m_mode == c_M_EXEC) begin
      chk("instr_out", instr_out, m_instr);
      chk("pc_out", 32'(pc_out), 32'(m_pc));
      chk("link_we", 32'(link_we), 32'(m_instr[31:27] == c_OP_JAL));
      if (m_instr[31:27] == c_OP_JAL) chk("link_data", link_data, 32'(m_pc + 1));
    end else begin
      chk("link_we_idle", 32'(link_we), 32'd0);
    end
  end

  task automatic cycle();
    @(negedge clock);
    #1;
  endtask

  task automatic chk_reset_values();
    chk("rst_addr", 32'(address_imem), 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_link_we", 32'(link_we), 32'd0);
    chk("rst_link_data", link_data, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
  endtask

  // Asserts reset mid-cycle; returns at the negedge of the first REQ cycle.
  task automatic apply_reset(input int offset);
    #(offset);
    reset = 1'b0;
    #1;
    chk_reset_values();
    stall   = 1'b0;
    rs_data = 32'd0;
    alu_ne  = 1'b0;
    alu_lt  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2;
    reset = 1'b1;
    cycle();
  endtask

  task automatic fill_mem(input logic [31:0] word);
    for (int i = 0; i < 4096; i++) mem[i] = word;
  endtask

  // Called at a REQ cycle; walks one instruction through EXEC with literal checks.
  task automatic exec_one(input int addr, input logic [31:0] rs, input bit ne, input bit lt,
                          input int stalls, input bit exp_lw, input logic [31:0] exp_link);
    chk("d_req_addr", 32'(address_imem), 32'(addr));
    chk("d_req_valid", 32'(instr_valid), 32'd0);
    rs_data = rs;
    alu_ne  = ne;
    alu_lt  = lt;
    stall   = (stalls > 0);
    cycle();
    for (int i = 0; i <= stalls; i++) begin
      chk("d_exec_valid", 32'(instr_valid), 32'd1);
      chk("d_exec_pc", 32'(pc_out), 32'(addr));
      chk("d_exec_addr", 32'(address_imem), 32'(addr));
      chk("d_exec_instr", instr_out, mem[addr]);
      chk("d_link_we", 32'(link_we), 32'(exp_lw));
      if (exp_lw) chk("d_link_data", link_data, exp_link);
      stall = (i < stalls);
      cycle();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0]  op;
    logic [26:0] f;
    case ($urandom_range(0, 9))
      0:       op = c_OP_J;
      1:       op = c_OP_JAL;
      2:       op = c_OP_JR;
      3:       op = c_OP_BNE;
      4:       op = c_OP_BLT;
      5:       op = c_OP_BEX;
      6:       op = c_OP_SETX;
      7:       op = c_OP_ADDI;
      8:       op = 5'd0;
      default: op = 5'($urandom);
    endcase
    f = 27'($urandom);
    if ($urandom_range(0, 5) == 0) f = 27'(c_HALT);
    return {op, f};
  endfunction

  task automatic drive_random();
    stall  = ($urandom_range(0, 3) == 0);
    alu_ne = 1'($urandom_range(0, 1));
    alu_lt = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 3))
      0:       rs_data = 32'd0;
      1:       rs_data = 32'd17;
      2:       rs_data = $urandom & 32'hFFFF_F000;
      default: rs_data = $urandom;
    endcase
  endtask

  initial begin
    // Model anchors computed by hand.
    chk("m_bne_taken", 32'(ref_next_pc(5, enc(c_OP_BNE, 32'h1FFFD), 0, 1, 0)), 32'd3);
    chk("m_bne_not",   32'(ref_next_pc(5, enc(c_OP_BNE, 32'h1FFFD), 0, 0, 0)), 32'd6);
    chk("m_wrap",      32'(ref_next_pc(4095, 32'd0, 0, 0, 0)), 32'd0);
    chk("m_bex_zero",  32'(ref_next_pc(0, enc(c_OP_BEX, 17), 0, 0, 0)), 32'd1);
    chk("m_bex_set",   32'(ref_next_pc(0, enc(c_OP_BEX, 17), 5, 0, 0)), 32'd17);
    chk("m_jr",        32'(ref_next_pc(10, enc(c_OP_JR, 0), 32'h0000_1011, 0, 0)), 32'd17);
    chk("m_blt_back",  32'(ref_next_pc(0, enc(c_OP_BLT, 32'h1FFFF), 0, 0, 1)), 32'd0);

    // Run 1: sequential fetch, jal link, bne both ways, PC wrap.
    fill_mem(enc(c_OP_ADDI, 0));
    mem[3]    = enc(c_OP_JAL, 10);
    mem[10]   = enc(c_OP_J, 5);
    mem[5]    = enc(c_OP_BNE, 32'h1FFFD);
    mem[6]    = enc(c_OP_J, 4095);
    mem[4095] = 32'd0;
    apply_reset(1);
    exec_one(0,    0, 0, 0, 0, 0, 0);
    exec_one(1,    0, 0, 0, 0, 0, 0);
    exec_one(2,    0, 0, 0, 0, 0, 0);
    exec_one(3,    0, 0, 0, 0, 1, 32'h0000_0004);
    exec_one(10,   0, 0, 0, 0, 0, 0);
    exec_one(5,    0, 1, 0, 0, 0, 0);
    exec_one(3,    0, 0, 0, 0, 1, 32'h0000_0004);
    exec_one(10,   0, 0, 0, 0, 0, 0);
    exec_one(5,    0, 0, 0, 0, 0, 0);
    exec_one(6,    0, 0, 0, 0, 0, 0);
    exec_one(4095, 0, 0, 0, 0, 0, 0);
    exec_one(0,    0, 0, 0, 0, 0, 0);

    // Run 2: bex not taken, then taken into the halt PC.
    fill_mem(enc(c_OP_ADDI, 0));
    mem[0] = enc(c_OP_BEX, 17);
    mem[1] = enc(c_OP_J, 0);
    apply_reset(3);
    exec_one(0, 32'd0, 0, 0, 0, 0, 0);
    exec_one(1, 32'd0, 0, 0, 0, 0, 0);
    exec_one(0, 32'd5, 0, 0, 0, 0, 0);
    chk("d_halt_req_addr", 32'(address_imem), 32'd17);
    cycle();
    chk("d_bex_halted", 32'(halted), 32'd1);
    chk("d_bex_valid", 32'(instr_valid), 32'd0);

    // Run 3: stalled jal, then jr into the halt PC.
    fill_mem(enc(c_OP_ADDI, 0));
    mem[2]  = enc(c_OP_JAL, 10);
    mem[10] = enc(c_OP_JR, 0);
    apply_reset(2);
    exec_one(0,  0, 0, 0, 0, 0, 0);
    exec_one(1,  0, 0, 0, 0, 0, 0);
    exec_one(2,  0, 0, 0, 3, 1, 32'h0000_0003);
    exec_one(10, 32'h0000_0011, 0, 0, 0, 0, 0);
    chk("d_jr_req_addr", 32'(address_imem), 32'h011);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("d_jr_halted", 32'(halted), 32'd1);
      chk("d_jr_valid", 32'(instr_valid), 32'd0);
    end

    // Run 4: reset lands in the middle of an EXEC cycle.
    fill_mem(enc(c_OP_JAL, 9));
    apply_reset(1);
    cycle();
    chk("d_pre_rst_valid", 32'(instr_valid), 32'd1);
    chk("d_pre_rst_link", 32'(link_we), 32'd1);
    apply_reset(4);

    // Randomized episodes, each ended by an asynchronous reset at a random offset.
    for (int ep = 0; ep < 30; ep++) begin
      int n;
      for (int i = 0; i < 4096; i++) mem[i] = rand_instr();
      apply_reset($urandom_range(0, 6));
      n = $urandom_range(60, 300);
      for (int c = 0; c < n; c++) begin
        drive_random();
        cycle();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
